switch_debounce: RTL and testbench

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

---
 rtl/switch_debounce.sv | 130 +++++++++++++
 tb/tb_switch_debounce.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// Switch debouncer with a change-event handshake.
//
// Each raw switch bit is synchronised, sampled once per debounce tick into a
// short history, and only accepted onto sw_stable once the history is
// unanimous. Accepted changes raise a valid/ready event that reports which
// bits moved since the last accepted event and the current debounced level.
//
// Parameters:
//   WIDTH          number of switch inputs
//   TICK_CYCLES    clock cycles per debounce sample tick (>= 2)
//   STABLE_SAMPLES consecutive equal samples needed to accept a level (>= 2)
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   sw         raw asynchronous switch levels
//   sw_stable  debounced switch levels (registered)
//   led        combinational copy of sw_stable
//   chg_valid  change event pending
//   chg_ready  consumer accepts the pending event
//   chg_mask   bits changed since the last accepted event
//   chg_value  sw_stable at the most recent change
module switch_debounce #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned TICK_CYCLES    = 100000,
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] led,
  output logic             chg_valid,
  input  logic             chg_ready,
  output logic [WIDTH-1:0] chg_mask,
  output logic [WIDTH-1:0] chg_value
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_CYCLES - 1);

  // Two-flop synchroniser; sync2_q is the only consumer-visible copy of sw.
  logic [WIDTH-1:0] sync1_q, sync2_q;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;

  logic [WIDTH-1:0][STABLE_SAMPLES-1:0] hist_q, hist_d;
  logic [WIDTH-1:0]                     stable_q, stable_d;
  logic [WIDTH-1:0]                     diff;

  logic             chg_valid_q, chg_valid_d;
  logic [WIDTH-1:0] chg_mask_q, chg_mask_d;
  logic [WIDTH-1:0] chg_value_q, chg_value_d;

  // Sample tick: high for exactly one cycle per TICK_CYCLES.
  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  // History shift and acceptance. The freshly shifted history is what gets
  // judged, so a level is accepted on the same tick as its final sample.
  always_comb begin
    hist_d   = hist_q;
    stable_d = stable_q;
    if (tick) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        hist_d[i] = {hist_q[i][STABLE_SAMPLES-2:0], sync2_q[i]};
        if (&hist_d[i]) begin
          stable_d[i] = 1'b1;
        end else if (~|hist_d[i]) begin
          stable_d[i] = 1'b0;
        end
      end
    end
    diff = stable_d ^ stable_q;
  end

  // Change-event handshake. While pending, changes accumulate into the mask
  // so nothing is lost; a transfer restarts the mask from this edge's diff.
  always_comb begin
    chg_valid_d = chg_valid_q;
    chg_mask_d  = chg_mask_q;
    chg_value_d = chg_value_q;
    if (diff != '0) begin
      chg_value_d = stable_d;
    end
    if (!chg_valid_q) begin
      if (diff != '0) begin
        chg_valid_d = 1'b1;
        chg_mask_d  = diff;
      end
    end else if (chg_ready) begin
      chg_valid_d = (diff != '0);
      chg_mask_d  = diff;
    end else begin
      chg_mask_d  = chg_mask_q | diff;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cnt_q       <= '0;
      hist_q      <= '0;
      stable_q    <= '0;
      chg_valid_q <= 1'b0;
      chg_mask_q  <= '0;
      chg_value_q <= '0;
    end else begin
      sync1_q     <= sw;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      hist_q      <= hist_d;
      stable_q    <= stable_d;
      chg_valid_q <= chg_valid_d;
      chg_mask_q  <= chg_mask_d;
      chg_value_q <= chg_value_d;
    end
  end

  assign sw_stable = stable_q;
  assign led       = stable_q;
  assign chg_valid = chg_valid_q;
  assign chg_mask  = chg_mask_q;
  assign chg_value = chg_value_q;

endmodule

// File: tb/tb_switch_debounce.sv
module tb_switch_debounce;

  localparam int W    = 16;
  localparam int TICK = 4;
  localparam int STAB = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  sw = '0;
  logic [W-1:0]  sw_stable, led, chg_mask, chg_value;
  logic          chg_valid;
  logic          chg_ready = 1'b0;

  switch_debounce #(
    .WIDTH         (W),
    .TICK_CYCLES   (TICK),
    .STABLE_SAMPLES(STAB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .sw_stable(sw_stable),
    .led      (led),
    .chg_valid(chg_valid),
    .chg_ready(chg_ready),
    .chg_mask (chg_mask),
    .chg_value(chg_value)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected transfers: {mask, value}.
  logic [31:0] exp_q[$];

  // Reference model, written as per-bit run lengths rather than histories.
  logic         model_on = 1'b0;
  logic [W-1:0] m_s1, m_s2, m_stable, m_mask, m_val;
  logic         m_valid;
  int           m_cnt;
  int           m_run[W];
  logic         m_last[W];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic wait_stable(input logic [W-1:0] want, input int limit, input string name);
    int k;
    k = 0;
    while (sw_stable !== want && k < limit) begin
      cyc(1);
      k++;
    end
    check(name, 32'(sw_stable), 32'(want));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_stable"}, 32'(sw_stable), 32'h0);
    check({name, "_led"}, 32'(led), 32'h0);
    check({name, "_valid"}, 32'(chg_valid), 32'h0);
    check({name, "_mask"}, 32'(chg_mask), 32'h0);
    check({name, "_value"}, 32'(chg_value), 32'h0);
  endtask

  task automatic model_step();
    logic [W-1:0] ns, d;
    logic         tk;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_mask = '0; m_val = '0;
      m_valid = 1'b0; m_cnt = 0;
      for (int b = 0; b < W; b++) begin
        m_run[b]  = STAB;
        m_last[b] = 1'b0;
      end
    end else begin
      tk = (m_cnt == TICK - 1);
      if (model_on && m_valid && chg_ready) exp_q.push_back({m_mask, m_val});
      ns = m_stable;
      if (tk) begin
        for (int b = 0; b < W; b++) begin
          if (m_s2[b] == m_last[b]) begin
            if (m_run[b] < STAB) m_run[b]++;
          end else begin
            m_run[b]  = 1;
            m_last[b] = m_s2[b];
          end
          if (m_run[b] == STAB) ns[b] = m_last[b];
        end
      end
      d = ns ^ m_stable;
      if (!m_valid) begin
        if (d != '0) begin
          m_valid = 1'b1;
          m_mask  = d;
          m_val   = ns;
        end
      end else if (chg_ready) begin
        m_valid = (d != '0);
        m_mask  = d;
        if (d != '0) m_val = ns;
      end else begin
        m_mask = m_mask | d;
        if (d != '0) m_val = ns;
      end
      m_stable = ns;
      m_cnt    = tk ? 0 : m_cnt + 1;
      m_s2     = m_s1;
      m_s1     = sw;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: a transfer seen before an edge is scored after that edge.
  logic         pend = 1'b0;
  logic [W-1:0] pend_mask, pend_val;
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL xfer_unexpected: got mask %h value %h, expected no transfer",
                   pend_mask, pend_val);
        end else begin
          e = exp_q.pop_front();
          check("xfer_mask", 32'(pend_mask), 32'(e[31:16]));
          check("xfer_value", 32'(pend_val), 32'(e[15:0]));
        end
      end
      pend      = chg_valid && chg_ready && !reset;
      pend_mask = chg_mask;
      pend_val  = chg_value;
      if (model_on) begin
        check("rnd_stable", 32'(sw_stable), 32'(m_stable));
        check("rnd_led", 32'(led), 32'(m_stable));
        check("rnd_valid", 32'(chg_valid), 32'(m_valid));
        check("rnd_mask", 32'(chg_mask), 32'(m_mask));
        check("rnd_value", 32'(chg_value), 32'(m_val));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with a switch already high, then first acceptance.
    sw = 16'h0001;
    #1;
    do_reset();
    check_all_zero("reset");
    wait_stable(16'h0001, 14, "first_stable");
    check("first_valid", 32'(chg_valid), 32'h1);
    check("first_mask", 32'(chg_mask), 32'h0001);
    check("first_value", 32'(chg_value), 32'h0001);
    exp_q.push_back({16'h0001, 16'h0001});
    chg_ready = 1'b1;
    cyc(1);
    chg_ready = 1'b0;
    check("first_clear_valid", 32'(chg_valid), 32'h0);
    check("first_clear_mask", 32'(chg_mask), 32'h0);
    check("first_hold_value", 32'(chg_value), 32'h0001);

    // Bit 3 bounces every 4 clocks: each tick sees the opposite level.
    for (int i = 0; i < 10; i++) begin
      sw[3] = ~sw[3];
      cyc(4);
      check("bounce_bit3", 32'(sw_stable[3]), 32'h0);
      check("bounce_valid", 32'(chg_valid), 32'h0);
    end
    cyc(16);

    // Accumulate two changes while the consumer stalls.
    sw = '0;
    do_reset();
    sw = 16'h0001;
    chg_ready = 1'b1;
    cyc(3);
    check("idle_ready_valid", 32'(chg_valid), 32'h0);
    check("idle_ready_mask", 32'(chg_mask), 32'h0);
    chg_ready = 1'b0;
    wait_stable(16'h0001, 14, "acc_stable0");
    check("acc_mask0", 32'(chg_mask), 32'h0001);
    sw = 16'h0021;
    wait_stable(16'h0021, 14, "acc_stable5");
    check("acc_valid", 32'(chg_valid), 32'h1);
    check("acc_mask", 32'(chg_mask), 32'h0021);
    check("acc_value", 32'(chg_value), 32'h0021);
    exp_q.push_back({16'h0021, 16'h0021});
    chg_ready = 1'b1;
    cyc(1);
    chg_ready = 1'b0;
    check("acc_clear_valid", 32'(chg_valid), 32'h0);
    check("acc_clear_mask", 32'(chg_mask), 32'h0);

    // Transfer on the same edge as a new change (bit 7 accepted at edge 24).
    sw = '0;
    do_reset();
    sw = 16'h0001;
    cyc(12);
    check("same_pre_stable", 32'(sw_stable), 32'h0001);
    check("same_pre_mask", 32'(chg_mask), 32'h0001);
    sw = 16'h0081;
    cyc(11);
    check("same_pre_valid", 32'(chg_valid), 32'h1);
    exp_q.push_back({16'h0001, 16'h0001});
    chg_ready = 1'b1;
    cyc(1);
    chg_ready = 1'b0;
    check("same_valid", 32'(chg_valid), 32'h1);
    check("same_mask", 32'(chg_mask), 32'h0080);
    check("same_value", 32'(chg_value), 32'h0081);
    exp_q.push_back({16'h0080, 16'h0081});
    chg_ready = 1'b1;
    cyc(1);
    chg_ready = 1'b0;
    check("same_clear_valid", 32'(chg_valid), 32'h0);

    // Reset after one sample discards history; full latency from release.
    sw = '0;
    do_reset();
    sw = 16'hFFFF;
    cyc(4);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check_all_zero("midreset");
    cyc(11);
    check("midreset_early_stable", 32'(sw_stable), 32'h0);
    check("midreset_early_valid", 32'(chg_valid), 32'h0);
    cyc(1);
    check("midreset_stable", 32'(sw_stable), 32'hFFFF);
    check("midreset_led", 32'(led), 32'hFFFF);
    check("midreset_valid", 32'(chg_valid), 32'h1);
    check("midreset_mask", 32'(chg_mask), 32'hFFFF);
    check("midreset_value", 32'(chg_value), 32'hFFFF);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check_all_zero("pendreset");
    cyc(1);
    check("pendreset_next_valid", 32'(chg_valid), 32'h0);

    // Random traffic against the model.
    sw = '0;
    do_reset();
    model_on = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 15) == 0) sw = sw ^ (16'($urandom) & 16'($urandom));
      chg_ready = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 1999) == 0);
      cyc(1);
    end
    reset     = 1'b0;
    chg_ready = 1'b0;
    cyc(2);
    model_on = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
